// File: rtl/dmem_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wbuf
// Purpose  : Posted-write buffer and read initiator between the MIPS data
//            port and a slower multi-cycle data memory. Stores are queued in
//            a small circular buffer and drained through a req/ack
//            handshake. Loads are forwarded from the buffer on an address
//            match. A load miss issues a memory read and stalls the
//            processor until the data comes back.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous reset, active low
//   memwrite   in   1   processor store request
//   memread    in   1   processor load request
//   dataadr    in  32   processor byte address (bits [31:2] used)
//   writedata  in  32   store data
//   readdata   out 32   load data to the processor
//   stall      out  1   processor must hold its inputs
//   mem_req    out  1   memory transaction request (registered)
//   mem_we     out  1   1 = write, 0 = read (registered)
//   mem_adr    out 32   word-aligned memory address (registered)
//   mem_wd     out 32   memory write data (registered)
//   mem_rd     in  32   memory read data, valid with mem_ack on a read
//   mem_ack    in   1   single-cycle transaction completion
// ============================================================================
module dmem_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  input  logic        mem_ack
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];
  localparam logic [PW:0] CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RDONE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t          state_q, state_d;

  logic [AW-1:0]   fifo_adr_q [DEPTH];
  logic [31:0]     fifo_dat_q [DEPTH];
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [PW:0]     count_q, count_d;

  logic            mem_req_q, mem_req_d;
  logic            mem_we_q,  mem_we_d;
  logic [31:0]     mem_adr_q, mem_adr_d;
  logic [31:0]     mem_wd_q,  mem_wd_d;
  logic [31:0]     rd_lat_q,  rd_lat_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [AW-1:0]   w_word;
  logic            w_full;
  logic            w_enq;
  logic            w_pop;
  logic            w_ld;
  logic            w_hit;
  logic [31:0]     w_hit_dat;
  logic [PW-1:0]   w_idx;
  logic            unused_lsbs;

  assign w_word      = dataadr[AW+1:2];
  assign unused_lsbs = ^dataadr[1:0];
  assign w_full      = (count_q == FULL_CNT);

  // A store is accepted only with room in the buffer as seen at the start of
  // the cycle; a pop in the same cycle does not free a slot until next cycle.
  assign w_enq = memwrite && !w_full;

  // A simultaneous store and load is handled as a store only.
  assign w_ld  = memread && !memwrite;

  // Scan valid entries from oldest to newest so the newest match wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_dat = '0;
    w_idx     = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = head_q + k[PW-1:0];
      if ((k[PW:0] < count_q) && (fifo_adr_q[w_idx] == w_word)) begin
        w_hit     = 1'b1;
        w_hit_dat = fifo_dat_q[w_idx];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transaction FSM: next state and registered memory-side outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    mem_adr_d = mem_adr_q;
    mem_wd_d  = mem_wd_q;
    rd_lat_d  = rd_lat_q;
    w_pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A miss cannot alias any buffered address, so the read may safely
        // overtake the pending writes.
        if (w_ld && !w_hit) begin
          state_d   = S_READ;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b0;
          mem_adr_d = 32'({w_word, 2'b00});
        end else if (count_q != '0) begin
          state_d   = S_WRITE;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
          mem_adr_d = 32'({fifo_adr_q[head_q], 2'b00});
          mem_wd_d  = fifo_dat_q[head_q];
        end
      end

      S_WRITE: begin
        if (mem_ack) begin
          w_pop     = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_READ: begin
        if (mem_ack) begin
          rd_lat_d  = mem_rd;
          mem_req_d = 1'b0;
          state_d   = S_RDONE;
        end
      end

      S_RDONE: begin
        // The processor takes the latched data and advances at this edge.
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_adr_q <= '0;
      mem_wd_q  <= '0;
      rd_lat_q  <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      mem_adr_q <= mem_adr_d;
      mem_wd_q  <= mem_wd_d;
      rd_lat_q  <= rd_lat_d;
    end
  end

  // --------------------------------------------------------------------------
  // Write buffer pointers and occupancy
  // --------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    case ({w_enq, w_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (w_enq) begin
        tail_q <= tail_q + PTR_ONE;
      end
      if (w_pop) begin
        head_q <= head_q + PTR_ONE;
      end
    end
  end

  // Entry payload needs no reset: occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      fifo_adr_q[tail_q] <= w_word;
      fifo_dat_q[tail_q] <= writedata;
    end
  end

  // --------------------------------------------------------------------------
  // Processor-side outputs
  // --------------------------------------------------------------------------
  // Both are forced quiet while reset is held so the processor sees an idle
  // port even if it keeps a request asserted.
  always_comb begin
    stall = 1'b0;
    if (reset) begin
      if (memwrite && w_full) begin
        stall = 1'b1;
      end else if (w_ld && !w_hit && (state_q != S_RDONE)) begin
        stall = 1'b1;
      end
    end
  end

  always_comb begin
    readdata = '0;
    if (reset) begin
      if (state_q == S_RDONE) begin
        readdata = rd_lat_q;
      end else if (w_ld && w_hit) begin
        readdata = w_hit_dat;
      end
    end
  end

  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;
  assign mem_adr = mem_adr_q;
  assign mem_wd  = mem_wd_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_wbuf
// Purpose  : Self-checking bench for dmem_wbuf. A memory responder acks
//            requests after a programmable delay and checks each transaction
//            against queues of expected writes and reads filled when the
//            processor-side stimulus is driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_wbuf;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic        memread;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_ack;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  txn_t wr_q[$];
  txn_t rd_q[$];

  int n_vec = 0;
  int n_err = 0;

  bit ack_en     = 1'b0;
  int ack_delay  = 0;
  int n_acks     = 0;
  int n_reads    = 0;
  int rd_wr_left = -1;

  always #5 clk = ~clk;

  dmem_wbuf #(
    .DEPTH(4),
    .AW   (30)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .memread  (memread),
    .dataadr  (dataadr),
    .writedata(writedata),
    .readdata (readdata),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_adr  (mem_adr),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd),
    .mem_ack  (mem_ack)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Memory responder and scoreboard
  // --------------------------------------------------------------------------
  int          wait_cnt;
  bit          in_txn;
  logic        f_we;
  logic [31:0] f_adr;
  logic [31:0] f_wd;
  txn_t        e;

  initial begin
    mem_ack  = 1'b0;
    mem_rd   = '0;
    wait_cnt = 0;
    in_txn   = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        check_val("req_gap", 32'(mem_req), 32'd0);
        in_txn   = 1'b0;
        wait_cnt = 0;
      end else if (mem_req !== 1'b1) begin
        in_txn   = 1'b0;
        wait_cnt = 0;
      end else begin
        if (!in_txn) begin
          in_txn = 1'b1;
          f_we   = mem_we;
          f_adr  = mem_adr;
          f_wd   = mem_wd;
        end
        if (ack_en) begin
          if (wait_cnt >= ack_delay) begin
            check_val("hold_we",  32'(mem_we), 32'(f_we));
            check_val("hold_adr", mem_adr, f_adr);
            check_val("hold_wd",  mem_wd,  f_wd);
            if (mem_we) begin
              check_val("wr_expected", 32'(wr_q.size() > 0), 32'd1);
              if (wr_q.size() > 0) begin
                e = wr_q.pop_front();
                check_val("wr_adr", mem_adr, e.adr);
                check_val("wr_dat", mem_wd,  e.dat);
              end
            end else begin
              check_val("rd_expected", 32'(rd_q.size() > 0), 32'd1);
              rd_wr_left = wr_q.size();
              n_reads++;
              if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                check_val("rd_adr", mem_adr, e.adr);
                mem_rd = e.dat;
              end
            end
            mem_ack = 1'b1;
            n_acks++;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Processor-side drivers (called just after a rising edge)
  // --------------------------------------------------------------------------
  task automatic do_store(input logic [31:0] adr, input logic [31:0] dat,
                          input int exp_stalls);
    int ns;
    ns        = 0;
    memwrite  = 1'b1;
    memread   = 1'b0;
    dataadr   = adr;
    writedata = dat;
    @(negedge clk);
    while (stall === 1'b1 && ns < 50) begin
      ns++;
      @(negedge clk);
    end
    check_val("st_stalls", 32'(ns), 32'(exp_stalls));
    wr_q.push_back('{adr: adr, dat: dat});
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] adr, input logic [31:0] exp_rd,
                         input int exp_stalls, input bit miss);
    int ns;
    ns = 0;
    if (miss) rd_q.push_back('{adr: adr, dat: exp_rd});
    memread  = 1'b1;
    memwrite = 1'b0;
    dataadr  = adr;
    @(negedge clk);
    while (stall === 1'b1 && ns < 50) begin
      check_val("ld_rd_zero", readdata, 32'd0);
      ns++;
      @(negedge clk);
    end
    check_val("ld_stalls", 32'(ns), 32'(exp_stalls));
    check_val("ld_data", readdata, exp_rd);
    @(posedge clk);
    #1;
    memread = 1'b0;
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    do begin
      @(posedge clk);
      #1;
      i++;
    end while ((wr_q.size() != 0 || rd_q.size() != 0 || mem_req === 1'b1 ||
                mem_ack === 1'b1) && i < 200);
    check_val("drain", 32'(wr_q.size() + rd_q.size()), 32'd0);
  endtask

  // --------------------------------------------------------------------------
  // Sequence
  // --------------------------------------------------------------------------
  initial begin
    int n0;
    int nr;
    int nh;

    reset     = 1'b0;
    memwrite  = 1'b0;
    memread   = 1'b0;
    dataadr   = '0;
    writedata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_req",   32'(mem_req), 32'd0);
    check_val("rst_we",    32'(mem_we),  32'd0);
    check_val("rst_adr",   mem_adr,      32'd0);
    check_val("rst_wd",    mem_wd,       32'd0);
    check_val("rst_stall", 32'(stall),   32'd0);
    check_val("rst_rdata", readdata,     32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single store, ack two cycles after the request
    ack_en    = 1'b1;
    ack_delay = 2;
    do_store(32'h54, 32'd7, 0);
    @(posedge clk);
    #1;
    check_val("ss_req", 32'(mem_req), 32'd1);
    check_val("ss_we",  32'(mem_we),  32'd1);
    check_val("ss_adr", mem_adr,      32'h54);
    check_val("ss_wd",  mem_wd,       32'd7);
    wait_drain();

    // Fill the buffer with acks held off; fifth store waits for a pop
    ack_en    = 1'b0;
    ack_delay = 0;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h1000 + 32'(i * 4), 32'hA0 + 32'(i), 0);
    end
    fork
      do_store(32'h2000, 32'h55, 2);
      begin
        @(posedge clk);
        #2;
        ack_en = 1'b1;
      end
    join
    wait_drain();

    // Forwarding: newest of two matching entries wins, no memory read
    ack_en = 1'b0;
    do_store(32'h60, 32'hAA, 0);
    do_store(32'h60, 32'hBB, 0);
    nr = n_reads;
    do_load(32'h60, 32'hBB, 0, 1'b0);
    check_val("fw_still_write", 32'(mem_we), 32'd1);
    ack_en = 1'b1;
    wait_drain();
    check_val("fw_no_read", 32'(n_reads), 32'(nr));

    // Load miss overtakes two pending writes
    ack_en = 1'b0;
    do_store(32'h100, 32'd1, 0);
    do_store(32'h104, 32'd2, 0);
    do_store(32'h108, 32'd3, 0);
    n0        = n_acks;
    ack_delay = 0;
    ack_en    = 1'b1;
    for (int i = 0; i < 20 && n_acks == n0; i++) begin
      @(posedge clk);
      #1;
    end
    check_val("pr_first_ack", 32'(n_acks - n0), 32'd1);
    rd_wr_left = -1;
    do_load(32'h80, 32'h1234, 2, 1'b1);
    check_val("pr_wr_left", 32'(rd_wr_left), 32'd2);
    wait_drain();

    // One extra ack wait cycle adds one stall cycle
    ack_delay = 1;
    do_load(32'h300, 32'hCAFE, 3, 1'b1);
    wait_drain();

    // Reset while a read is outstanding, then reload the same address
    ack_en    = 1'b0;
    ack_delay = 0;
    memread   = 1'b1;
    dataadr   = 32'h200;
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clk);
    check_val("rr_req_seen", 32'(mem_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    check_val("rr_req",   32'(mem_req), 32'd0);
    check_val("rr_stall", 32'(stall),   32'd0);
    check_val("rr_rdata", readdata,     32'd0);
    memread = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b1;
    ack_en = 1'b1;
    do_load(32'h200, 32'h5555, 2, 1'b1);
    wait_drain();

    // Reset in the middle of a write abandons it and empties the buffer
    ack_en = 1'b0;
    do_store(32'h40, 32'h99, 0);
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clk);
    check_val("rw_req_seen", 32'(mem_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    check_val("rw_req",   32'(mem_req), 32'd0);
    check_val("rw_we",    32'(mem_we),  32'd0);
    check_val("rw_adr",   mem_adr,      32'd0);
    check_val("rw_stall", 32'(stall),   32'd0);
    check_val("rw_rdata", readdata,     32'd0);
    wr_q.delete();
    @(posedge clk);
    #1;
    reset  = 1'b1;
    ack_en = 1'b1;
    nh     = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req === 1'b1) nh++;
    end
    check_val("rw_no_req", 32'(nh), 32'd0);
    @(posedge clk);
    #1;

    check_val("q_empty", 32'(wr_q.size() + rd_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d errors so far", n_err);
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
- Posted-write buffer and read initiator between the MIPS data port and a slower multi-cycle data memory.
- Processor stores are queued and drained to memory through a req/ack handshake.
- Loads are forwarded from the buffer on an address match. On a miss, the block issues a memory read and stalls the processor.
- This is the initiator side of the data-memory interface: it drives requests, and the memory responds.

Parameters:
- DEPTH, 4, number of buffered writes (power of 2, at least 2).
- AW, 30, word-address width (dataadr[31:2]).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low (0 = reset asserted).
- memwrite  input  1  processor store request.
- memread  input  1  processor load request.
- dataadr  input  32  processor byte address; only bits [31:2] are used.
- writedata  input  32  store data.
- readdata  output  32  load data to the processor.
- stall  output  1  processor must hold all inputs and not advance.
- mem_req  output  1  memory transaction request (registered).
- mem_we  output  1  1 = write, 0 = read (registered).
- mem_adr  output  32  word-aligned address, {word address, 2'b00} (registered).
- mem_wd  output  32  memory write data (registered).
- mem_rd  input  32  memory read data; valid when mem_ack=1 and mem_we=0.
- mem_ack  input  1  single-cycle completion; may arrive in the same cycle mem_req rises.

Behaviour:
- Reset (asynchronous, reset=0):
  - FIFO emptied, state=IDLE.
  - mem_req=0, mem_we=0, mem_adr=0, mem_wd=0, read latch=0.
  - stall=0, readdata=0.
  - An outstanding transaction is abandoned; mem_req drops immediately.
- FIFO:
  - Circular buffer of {word address, data}, with head/tail pointers and a count from 0 to DEPTH. Pointers wrap modulo DEPTH.
  - Enqueue and pop may occur in the same cycle; count is then unchanged.
- Store:
  - If memwrite=1 and count<DEPTH, enqueue at the posedge; stall=0.
  - If count==DEPTH, stall=1 combinationally and nothing is enqueued. This holds even if a pop occurs that cycle; the store is accepted on the next cycle.
- Load hit:
  - If memread=1, compare the address against all valid entries. The newest matching entry wins.
  - On a hit, readdata = that entry's data combinationally, stall=0, and no memory access is made.
- Load miss: stall=1 until the RDONE cycle.
- Simultaneous memwrite and memread: treated as a store only.
- FSM states: IDLE, WRITE, READ, RDONE.
  - IDLE, memread miss (and memwrite=0): go to READ. Register mem_req=1, mem_we=0, mem_adr={dataadr[31:2],2'b00}. A read takes priority over draining; this is safe because a miss cannot alias a buffered address.
  - IDLE, otherwise, count>0: go to WRITE. Register mem_req=1, mem_we=1, mem_adr/mem_wd from the head entry.
  - IDLE, otherwise: stay in IDLE.
  - WRITE, mem_ack=1: pop the head, clear mem_req, go to IDLE. Otherwise hold all mem_* signals stable.
  - READ, mem_ack=1: latch mem_rd, clear mem_req, go to RDONE. Otherwise hold.
  - RDONE: readdata = latched value, stall=0, go to IDLE (the processor advances at this edge).
- In IDLE, mem_req=0 for at least one cycle between transactions. mem_ack while mem_req=0 is ignored.
- While in WRITE or READ, stores may still be enqueued if there is space. A load miss waits, with stall=1, until the FSM returns to IDLE.
- readdata=0 whenever there is neither a hit nor the RDONE state.
- Load miss latency with immediate ack: 2 stall cycles (IDLE→READ, READ→RDONE). Each additional ack wait cycle adds 1.

Test Plan:
- Reset: hold reset=0 mid-WRITE with mem_req=1 → mem_req=0 at once, stall=0, readdata=0. After release, no memory request occurs (buffer empty).
- Single store: dataadr=0x54, writedata=7, ack 2 cycles after req → next cycle mem_req=1, mem_we=1, mem_adr=0x54, mem_wd=7, all held stable until ack. mem_req=0 the following cycle, count=0.
- Full: 5 consecutive stores with mem_ack=0 → stores 1–4 accepted (stall=0); store 5 has stall=1. Pulse ack → store 5 accepted one cycle later, with wrap-around of the tail pointer verified.
- Forwarding: store 0x60=0xAA, then 0x60=0xBB, then load 0x60 with ack low → readdata=0xBB and stall=0 in the same cycle, with no mem read issued.
- Load miss priority: two stores pending, load 0x80, mem_rd=0x1234 with immediate ack → the read is issued before any write. stall=1 for exactly 2 cycles, readdata=0x1234 in RDONE, then the writes drain.
- Reset during READ, then a new load of the same address → a fresh read is issued, and the stale latched data is never returned.
